// File: rtl/cp0_unit.sv
// Coprocessor 0 for the P7 pipeline: holds SR, Cause, EPC and PRId. It raises
// the exception/interrupt flush request and serves mfc0, mtc0 and eret.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_victim_pc;

    // Requests are gated by reset so nothing is taken during the reset cycle.
    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl & ~reset;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl & ~reset;
    assign w_req     = w_int_req | w_exc_req;
    assign Req       = w_req;

    assign w_wr_sr     = en & (CP0Add == ADDR_SR);
    assign w_wr_epc    = en & (CP0Add == ADDR_EPC);
    assign w_victim_pc = BDIn ? (VPC - 32'd4) : VPC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= HWInt;
            if (w_req) begin
                // Flushed instruction: its mtc0 and any eret are dropped.
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
                r_epc     <= {w_victim_pc[31:2], 2'b00};
            end else begin
                if (w_wr_sr) begin
                    r_im  <= CP0In[15:10];
                    r_ie  <= CP0In[0];
                    r_exl <= EXLClr ? 1'b0 : CP0In[1];
                end else if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= {CP0In[31:2], 2'b00};
                end
            end
        end
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            ADDR_SR:    CP0Out = {16'd0, r_im, 8'd0, r_exl, r_ie};
            ADDR_CAUSE: CP0Out = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
            ADDR_EPC:   CP0Out = r_epc;
            ADDR_PRID:  CP0Out = PRID_VALUE;
            default:    CP0Out = '0;
        endcase
    end

    assign EPCOut = r_epc;

endmodule
